// File: rtl/line_buffer_pkg.sv
// Shared types and address helper for the two-line Sobel line buffer.
// Column fields are sized by PIX_W, which must match the controller's DATA_W.
package line_buffer_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t top;
        pixel_t mid;
        pixel_t bot;
        logic   eol;
        logic   eof;
    } column_t;

    // Bank 0 holds RAM words [0, line_w), bank 1 holds [line_w, 2*line_w).
    function automatic int unsigned line_addr(input logic bank,
                                              input int unsigned col,
                                              input int unsigned line_w);
        if (bank) begin
            return line_w + col;
        end
        return col;
    endfunction

endpackage

// File: rtl/window_skid_fifo.sv
// Two-entry column queue between the RAM read pipeline and the window stage.
// Simultaneous push and pop leave the count unchanged.
module window_skid_fifo
    import line_buffer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  column_t    data_i,
    output column_t    head_o,
    output logic [1:0] count_o
);

    column_t    mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;

    always_comb begin
        count_d = count_q + 2'(push_i) - 2'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Drives a sync_ram_block as a two-line circular buffer and emits vertical
// 3-pixel columns (rows y-2, y-1, y) once two lines have been primed.
module line_buffer_ctrl
    import line_buffer_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int LINE_W  = 640,
    parameter  int FRAME_H = 480,
    localparam int ADDR_W  = $clog2(2*LINE_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic [ADDR_W-1:0] ram_wr_addr_o,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_rd_addr_a_o,
    output logic              ram_rd_en_a_o,
    output logic [ADDR_W-1:0] ram_rd_addr_b_o,
    output logic              ram_rd_en_b_o,
    input  logic [DATA_W-1:0] ram_data_a_i,
    input  logic [DATA_W-1:0] ram_data_b_i,
    output logic [DATA_W-1:0] out_top_o,
    output logic [DATA_W-1:0] out_mid_o,
    output logic [DATA_W-1:0] out_bot_o,
    output logic              out_eol_o,
    output logic              out_eof_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int ROW_W = $clog2(FRAME_H);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              bank_q, bank_d;
    logic              pend_q;
    logic [DATA_W-1:0] bot_q;
    logic              eol_q;
    logic              eof_q;

    logic              acc;
    logic              col_last;
    logic              row_last;
    logic              row_ge2;
    logic              pop;
    logic [1:0]        q_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr_a;
    column_t           push_col;
    column_t           head;

    assign col_last = (col_q == COL_W'(LINE_W-1));
    assign row_last = (row_q == ROW_W'(FRAME_H-1));
    assign row_ge2  = (row_q >= ROW_W'(2));

    // pend_q plus the queue count is every column still owed downstream;
    // a pop this cycle frees a slot, so ready may follow out_ready_i directly.
    assign out_valid_o = (q_cnt != 2'd0);
    assign pop         = out_valid_o & out_ready_i;
    assign in_ready_o  = ((2'(pend_q) + q_cnt) < 2'd2) | pop;
    assign acc         = in_valid_i & in_ready_o;

    assign wr_addr   = ADDR_W'(line_addr(bank_q, 32'(col_q), LINE_W));
    assign rd_addr_a = ADDR_W'(line_addr(~bank_q, 32'(col_q), LINE_W));

    // Port B reads the word being overwritten; read-before-write yields row y-2.
    assign ram_wr_en_o     = acc;
    assign ram_wr_addr_o   = acc ? wr_addr : '0;
    assign ram_data_o      = acc ? in_data_i : '0;
    assign ram_rd_en_a_o   = acc & row_ge2;
    assign ram_rd_addr_a_o = ram_rd_en_a_o ? rd_addr_a : '0;
    assign ram_rd_en_b_o   = acc & row_ge2;
    assign ram_rd_addr_b_o = ram_rd_en_b_o ? wr_addr : '0;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        bank_d = bank_q;
        if (acc) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d  = '0;
                    bank_d = 1'b0;
                end else begin
                    row_d  = row_q + ROW_W'(1);
                    bank_d = ~bank_q;
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q  <= '0;
            row_q  <= '0;
            bank_q <= 1'b0;
            pend_q <= 1'b0;
            bot_q  <= '0;
            eol_q  <= 1'b0;
            eof_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            bank_q <= bank_d;
            pend_q <= acc & row_ge2;
            if (acc) begin
                bot_q <= in_data_i;
                eol_q <= col_last;
                eof_q <= col_last & row_last;
            end
        end
    end

    assign push_col.top = ram_data_b_i;
    assign push_col.mid = ram_data_a_i;
    assign push_col.bot = bot_q;
    assign push_col.eol = eol_q;
    assign push_col.eof = eof_q;

    window_skid_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pend_q),
        .pop_i   (pop),
        .data_i  (push_col),
        .head_o  (head),
        .count_o (q_cnt)
    );

    assign out_top_o = head.top;
    assign out_mid_o = head.mid;
    assign out_bot_o = head.bot;
    assign out_eol_o = head.eol;
    assign out_eof_o = head.eof;

endmodule
